// File: rtl/build_hash_issue_pkg.sv
// Shared definitions for the hash-join build issue path.
//   HASH_MULT          : 64-bit multiplicative (Fibonacci) hash constant
//   *_DEF              : default bucket/entry/address geometry
//   state_e            : issue FSM encoding (IDLE=0, RUN=1, DRAIN=2, DONE=3)
//   req_data_t         : 128-bit write data, key in [63:0], payload in [127:64]
package build_hash_issue_pkg;

    localparam logic [63:0] HASH_MULT       = 64'h9E3779B97F4A7C15;
    localparam int          HASH_BITS_DEF   = 16;
    localparam int          ENTRY_SHIFT_DEF = 4;
    localparam int          ADDR_W_DEF      = 48;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Packed MSB-first, so payload lands in [127:64] and key in [63:0].
    typedef struct packed {
        logic [63:0] payload;
        logic [63:0] key;
    } req_data_t;

endpackage

// File: rtl/build_hash_issue_mult_hash_stage.sv
// Registered 64x64 truncated multiply with bucket extraction.
// Shared with the probe engine, so it carries the key/payload alongside
// the product and exposes a valid bit.
//   clk, rst_n      : clock, async active-low reset
//   in_valid        : in_key/in_payload carry a tuple this cycle
//   in_key/payload  : tuple fields
//   s1_valid_out    : registered tuple valid
//   s1_key_out      : registered key
//   s1_payload_out  : registered payload
//   bucket_out      : top HASH_BITS of the registered product
module mult_hash_stage
    import build_hash_issue_pkg::*;
#(
    parameter int          HASH_BITS = HASH_BITS_DEF,
    parameter logic [63:0] MULT      = HASH_MULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [63:0]          in_key,
    input  logic [63:0]          in_payload,
    output logic                 s1_valid_out,
    output logic [63:0]          s1_key_out,
    output logic [63:0]          s1_payload_out,
    output logic [HASH_BITS-1:0] bucket_out
);

    logic        vld_d, vld_q;
    logic [63:0] prod_d, prod_q;
    logic [63:0] key_d, key_q;
    logic [63:0] payload_d, payload_q;

    // Only load on valid data so idle cycles do not toggle the wide regs.
    always_comb begin
        vld_d     = in_valid;
        prod_d    = prod_q;
        key_d     = key_q;
        payload_d = payload_q;
        if (in_valid) begin
            prod_d    = in_key * MULT;   // 64-bit result = product mod 2^64
            key_d     = in_key;
            payload_d = in_payload;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q     <= 1'b0;
            prod_q    <= '0;
            key_q     <= '0;
            payload_q <= '0;
        end else begin
            vld_q     <= vld_d;
            prod_q    <= prod_d;
            key_q     <= key_d;
            payload_q <= payload_d;
        end
    end

    assign s1_valid_out   = vld_q;
    assign s1_key_out     = key_q;
    assign s1_payload_out = payload_q;
    // Multiplicative hashing: the high bits mix every key bit.
    assign bucket_out     = prod_q[63 -: HASH_BITS];

endmodule

// File: rtl/build_hash_issue.sv
// Hash-table build issue stage. Pops (key, payload) pairs from the dual-lane
// tuple FIFO, hashes the key and emits one 16 B entry write per tuple.
//   clk, rst_n        : clock, async active-low reset
//   start_in          : pulse; latches num_tuples_in/base_addr_in, starts run
//   num_tuples_in     : tuples to consume
//   base_addr_in      : table base (entry aligned)
//   fifo_empty_in     : either FIFO lane empty
//   fifo_read_en_out  : pop both lanes, data valid next cycle
//   fifo_key_in       : lane 0 data
//   fifo_payload_in   : lane 1 data
//   req_afull_in      : downstream request FIFO almost full
//   req_valid_out     : write request valid (one cycle per tuple)
//   req_addr_out      : entry address
//   req_data_out      : {payload, key}
//   req_bucket_out    : bucket index
//   busy_out          : run or drain in progress
//   done_out          : run complete, held until next start
//   tuple_count_out   : requests emitted this run
module build_hash_issue
    import build_hash_issue_pkg::*;
#(
    parameter int          HASH_BITS   = HASH_BITS_DEF,
    parameter int          ENTRY_SHIFT = ENTRY_SHIFT_DEF,
    parameter int          ADDR_W      = ADDR_W_DEF,
    parameter logic [63:0] MULT        = HASH_MULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_in,
    input  logic [31:0]          num_tuples_in,
    input  logic [ADDR_W-1:0]    base_addr_in,
    input  logic                 fifo_empty_in,
    output logic                 fifo_read_en_out,
    input  logic [63:0]          fifo_key_in,
    input  logic [63:0]          fifo_payload_in,
    input  logic                 req_afull_in,
    output logic                 req_valid_out,
    output logic [ADDR_W-1:0]    req_addr_out,
    output logic [127:0]         req_data_out,
    output logic [HASH_BITS-1:0] req_bucket_out,
    output logic                 busy_out,
    output logic                 done_out,
    output logic [31:0]          tuple_count_out
);

    state_e              state_d, state_q;
    logic [31:0]         num_d, num_q;
    logic [ADDR_W-1:0]   base_d, base_q;
    logic [31:0]         issued_d, issued_q;
    logic [31:0]         emitted_d, emitted_q;
    logic                rd_vld_d, rd_vld_q;    // FIFO dout valid this cycle
    logic                req_valid_d, req_valid_q;
    logic [ADDR_W-1:0]   req_addr_d, req_addr_q;
    req_data_t           req_data_d, req_data_q;
    logic [HASH_BITS-1:0] req_bucket_d, req_bucket_q;

    logic                 s1_valid;
    logic [63:0]          s1_key;
    logic [63:0]          s1_payload;
    logic [HASH_BITS-1:0] s1_bucket;
    logic [ADDR_W-1:0]    bucket_ext;
    logic                 pop;

    // Afull is checked before empty matters: any pop with afull high could
    // overrun the 3-entry slack budgeted downstream.
    assign pop = (state_q == ST_RUN) && !fifo_empty_in && !req_afull_in &&
                 (issued_q != num_q);

    mult_hash_stage #(
        .HASH_BITS (HASH_BITS),
        .MULT      (MULT)
    ) u_hash (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (rd_vld_q),
        .in_key         (fifo_key_in),
        .in_payload     (fifo_payload_in),
        .s1_valid_out   (s1_valid),
        .s1_key_out     (s1_key),
        .s1_payload_out (s1_payload),
        .bucket_out     (s1_bucket)
    );

    always_comb begin
        bucket_ext                  = '0;
        bucket_ext[HASH_BITS-1:0]   = s1_bucket;
    end

    // Control FSM and counters.
    always_comb begin
        state_d   = state_q;
        num_d     = num_q;
        base_d    = base_q;
        issued_d  = issued_q;
        emitted_d = emitted_q;
        rd_vld_d  = pop;

        if (pop)      issued_d  = issued_q + 32'd1;
        if (s1_valid) emitted_d = emitted_q + 32'd1;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                // Pipeline is empty here, so clearing the counters is safe.
                if (start_in) begin
                    state_d   = ST_RUN;
                    num_d     = num_tuples_in;
                    base_d    = base_addr_in;
                    issued_d  = '0;
                    emitted_d = '0;
                end
            end
            ST_RUN: begin
                if (issued_q == num_q) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!rd_vld_q && !s1_valid && !req_valid_q) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output register: address add sits here, after the bucket is registered.
    always_comb begin
        req_valid_d  = s1_valid;
        req_addr_d   = req_addr_q;
        req_data_d   = req_data_q;
        req_bucket_d = req_bucket_q;
        if (s1_valid) begin
            req_addr_d         = base_q + (bucket_ext << ENTRY_SHIFT);
            req_data_d.key     = s1_key;
            req_data_d.payload = s1_payload;
            req_bucket_d       = s1_bucket;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            num_q        <= '0;
            base_q       <= '0;
            issued_q     <= '0;
            emitted_q    <= '0;
            rd_vld_q     <= 1'b0;
            req_valid_q  <= 1'b0;
            req_addr_q   <= '0;
            req_data_q   <= '0;
            req_bucket_q <= '0;
        end else begin
            state_q      <= state_d;
            num_q        <= num_d;
            base_q       <= base_d;
            issued_q     <= issued_d;
            emitted_q    <= emitted_d;
            rd_vld_q     <= rd_vld_d;
            req_valid_q  <= req_valid_d;
            req_addr_q   <= req_addr_d;
            req_data_q   <= req_data_d;
            req_bucket_q <= req_bucket_d;
        end
    end

    assign fifo_read_en_out = pop;
    assign req_valid_out    = req_valid_q;
    assign req_addr_out     = req_addr_q;
    assign req_data_out     = req_data_q;
    assign req_bucket_out   = req_bucket_q;
    assign busy_out         = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done_out         = (state_q == ST_DONE);
    assign tuple_count_out  = emitted_q;

endmodule

// File: tb/tb_build_hash_issue.sv
module tb_build_hash_issue;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start_in = 1'b0;
    logic [31:0]  num_tuples_in = '0;
    logic [47:0]  base_addr_in = '0;
    logic         fifo_empty_in = 1'b1;
    logic         fifo_read_en_out;
    logic [63:0]  fifo_key_in = '0;
    logic [63:0]  fifo_payload_in = '0;
    logic         req_afull_in = 1'b0;
    logic         req_valid_out;
    logic [47:0]  req_addr_out;
    logic [127:0] req_data_out;
    logic [15:0]  req_bucket_out;
    logic         busy_out;
    logic         done_out;
    logic [31:0]  tuple_count_out;

    build_hash_issue dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start_in         (start_in),
        .num_tuples_in    (num_tuples_in),
        .base_addr_in     (base_addr_in),
        .fifo_empty_in    (fifo_empty_in),
        .fifo_read_en_out (fifo_read_en_out),
        .fifo_key_in      (fifo_key_in),
        .fifo_payload_in  (fifo_payload_in),
        .req_afull_in     (req_afull_in),
        .req_valid_out    (req_valid_out),
        .req_addr_out     (req_addr_out),
        .req_data_out     (req_data_out),
        .req_bucket_out   (req_bucket_out),
        .busy_out         (busy_out),
        .done_out         (done_out),
        .tuple_count_out  (tuple_count_out)
    );

    always #5 clk = ~clk;

    typedef struct { logic [63:0] key; logic [63:0] payload; } tup_t;
    typedef struct { int due; logic [47:0] addr; logic [127:0] data; logic [15:0] bucket; } exp_t;

    tup_t         fq[$];          // upstream FIFO contents
    exp_t         eq[$];          // expected requests in issue order
    logic [15:0]  seen_b[$];
    logic [47:0]  seen_a[$];
    logic [127:0] seen_d[$];
    int           errors = 0;
    int           checks = 0;
    int           cyc = 0;
    bit           force_empty = 0;
    bit           afull = 0;
    int           m_num = 0, m_pops = 0, m_emit = 0;
    logic [47:0]  m_base = '0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: Fibonacci hash top 16 bits, entry = 16 bytes.
    function automatic exp_t model(input tup_t t, input int due);
        exp_t        e;
        logic [63:0] p;
        p        = t.key * 64'h9E3779B97F4A7C15;
        e.due    = due;
        e.bucket = 16'(p >> 48);
        e.addr   = m_base + 48'(e.bucket) * 48'd16;
        e.data   = {t.payload, t.key};
        return e;
    endfunction

    task automatic push_tuples(input int n, input bit rnd);
        tup_t t;
        for (int i = 0; i < n; i++) begin
            t.key     = rnd ? {$urandom, $urandom} : 64'(i);
            t.payload = rnd ? {$urandom, $urandom} : 64'(i + 'h100);
            fq.push_back(t);
        end
    endtask

    task automatic tick();
        bit   rd, st;
        tup_t t;
        bit   ev;
        fifo_empty_in = force_empty || (fq.size() == 0);
        req_afull_in  = afull;
        @(negedge clk);
        rd = fifo_read_en_out;
        st = start_in;
        if (rd) chk("pop_gating", {126'b0, (req_afull_in || fifo_empty_in), (m_pops >= m_num)}, 0);
        @(posedge clk);
        #1;
        cyc++;
        if (st) begin
            m_num = num_tuples_in; m_base = base_addr_in; m_pops = 0; m_emit = 0;
            start_in = 1'b0;
        end
        if (rd && rst_n && fq.size() > 0) begin
            t = fq.pop_front();
            m_pops++;
            eq.push_back(model(t, cyc + 2));
            fifo_key_in     = t.key;
            fifo_payload_in = t.payload;
        end else begin
            fifo_key_in     = {$urandom, $urandom};
            fifo_payload_in = {$urandom, $urandom};
        end
        ev = (eq.size() > 0) && (eq[0].due == cyc);
        chk("req_valid", req_valid_out, ev);
        if (ev && req_valid_out) begin
            chk("req_addr", req_addr_out, eq[0].addr);
            chk("req_data", req_data_out, eq[0].data);
            chk("req_bucket", req_bucket_out, eq[0].bucket);
            seen_a.push_back(req_addr_out);
            seen_b.push_back(req_bucket_out);
            seen_d.push_back(req_data_out);
            m_emit++;
            chk("tuple_count", tuple_count_out, m_emit);
        end
        if (ev) void'(eq.pop_front());
    endtask

    task automatic launch(input int num, input logic [47:0] base);
        num_tuples_in = num;
        base_addr_in  = base;
        start_in      = 1'b1;
        seen_a.delete(); seen_b.delete(); seen_d.delete();
        tick();
    endtask

    task automatic finish_run(input int num, input int maxcyc);
        for (int i = 0; i < maxcyc && !done_out; i++) tick();
        chk("done", done_out, 1);
        chk("busy_after_done", busy_out, 0);
        chk("drained", eq.size(), 0);
        chk("final_count", tuple_count_out, num);
        chk("pops", m_pops, num);
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_valid", req_valid_out, 0);
        chk("rst_addr", req_addr_out, 0);
        chk("rst_data", req_data_out, 0);
        chk("rst_bucket", req_bucket_out, 0);
        chk("rst_busy", busy_out, 0);
        chk("rst_done", done_out, 0);
        chk("rst_count", tuple_count_out, 0);
        chk("rst_rden", fifo_read_en_out, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();

        // Single tuple, key 1
        fq.push_back('{key: 64'h1, payload: 64'hAA});
        launch(1, 48'h1000);
        chk("busy_run", busy_out, 1);
        finish_run(1, 20);
        chk("t1_bucket", seen_b.size() ? seen_b[0] : 16'hx, 16'h9E37);
        chk("t1_addr", seen_a.size() ? seen_a[0] : 48'hx, 48'h9F370);
        chk("t1_data", seen_d.size() ? seen_d[0] : 128'hx, {64'hAA, 64'h1});

        // Keys 0,1,2 back-to-back
        for (int i = 0; i < 3; i++) fq.push_back('{key: 64'(i), payload: 64'(i + 5)});
        launch(3, 48'h0);
        finish_run(3, 20);
        chk("t2_n", seen_b.size(), 3);
        if (seen_b.size() == 3) begin
            chk("t2_b0", seen_b[0], 16'h0000);
            chk("t2_b1", seen_b[1], 16'h9E37);
            chk("t2_b2", seen_b[2], 16'h3C6E);
            chk("t2_a2", seen_a[2], 48'h3C6E0);
        end

        // num = 0: done within 2 cycles, nothing popped
        fq.push_back('{key: 64'h55, payload: 64'h66});
        launch(0, 48'h2000);
        finish_run(0, 2);
        chk("t3_fifo_untouched", fq.size(), 1);
        fq.delete();

        // Afull held with 10 queued
        afull = 1;
        push_tuples(10, 1);
        launch(10, 48'h123450);
        for (int i = 0; i < 8; i++) tick();
        chk("t4_no_pop_afull", m_pops, 0);
        chk("t4_busy", busy_out, 1);
        afull = 0;
        finish_run(10, 40);

        // Empty toggling; extra tuples stay queued
        push_tuples(6, 1);
        launch(4, 48'h40);
        for (int i = 0; i < 40 && !done_out; i++) begin
            force_empty = ~force_empty;
            tick();
        end
        force_empty = 0;
        finish_run(4, 5);
        chk("t5_leftover", fq.size(), 2);
        fq.delete();

        // Reset mid-run
        push_tuples(5, 1);
        launch(5, 48'h800);
        for (int i = 0; i < 20 && m_pops < 2; i++) tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("mr_valid", req_valid_out, 0);
        chk("mr_busy", busy_out, 0);
        chk("mr_done", done_out, 0);
        chk("mr_rden", fifo_read_en_out, 0);
        eq.delete();
        m_num = 0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        fq.delete();
        push_tuples(4, 1);
        launch(2, 48'hA000);
        finish_run(2, 20);
        chk("mr_leftover", fq.size(), 2);
        fq.delete();

        // Randomized run with random afull/empty
        push_tuples(25, 1);
        launch(20, {16'h0, $urandom} & 48'hFFFF_FFFF_FFF0);
        for (int i = 0; i < 400 && !done_out; i++) begin
            afull       = ($urandom_range(0, 3) == 0);
            force_empty = ($urandom_range(0, 3) == 0);
            tick();
        end
        afull = 0;
        force_empty = 0;
        finish_run(20, 10);
        chk("rnd_leftover", fq.size(), 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/build_hash_issue.md
Name: build_hash_issue

Overview:
- Consumes (key, payload) tuple pairs from the dual-lane sync FIFO in the build engine.
- Hashes each key with a multiplicative hash and emits one hash-table write request per tuple toward the memory-request FIFO.
- A start/done control FSM bounds the run to a programmed tuple count.
- Sits between the input tuple FIFO pair and the memory write queue.

Parameters:
- HASH_BITS, 16: bucket index width; the table holds 2^HASH_BITS buckets.
- ENTRY_SHIFT, 4: log2 of the entry size in bytes (16 B entry = key + payload).
- ADDR_W, 48: memory address width.
- HASH_MULT, 64'h9E3779B97F4A7C15: multiplicative hash constant.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start_in  in  1  one-cycle pulse; latches num_tuples_in and base_addr_in, begins a run
- num_tuples_in  in  32  tuples to consume this run
- base_addr_in  in  ADDR_W  hash table base address (entry-aligned)
- fifo_empty_in  in  1  upstream FIFO pair empty (either lane empty)
- fifo_read_en_out  out  1  pop both lanes; data is valid the next cycle
- fifo_key_in  in  64  lane 0 data (key)
- fifo_payload_in  in  64  lane 1 data (payload)
- req_afull_in  in  1  downstream request FIFO almost-full (prog_full)
- req_valid_out  out  1  write request valid, single cycle per tuple
- req_addr_out  out  ADDR_W  entry address
- req_data_out  out  128  {payload, key}
- req_bucket_out  out  HASH_BITS  bucket index (for downstream collision tracking)
- busy_out  out  1  high in RUN or DRAIN
- done_out  out  1  high in DONE until the next start_in
- tuple_count_out  out  32  requests emitted this run

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counters 0, pipeline valid bits cleared. Reset is async assert; deassertion is sampled on clk.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE/DONE -> RUN on start_in: latch count and base, clear issued/emitted counters, drop done_out.
  - RUN -> DRAIN when issued == num (includes num = 0 on the first RUN cycle).
  - DRAIN -> DONE when all three pipeline valid bits are 0.
  - start_in in RUN or DRAIN is ignored.
- Issue: fifo_read_en_out = (state==RUN) & ~fifo_empty_in & ~req_afull_in & (issued != num). Combinational from registered state and inputs. issued increments on each pop.
- Pipeline, read at cycle T:
  - S1 (T+1): FIFO dout is valid; compute prod = key * HASH_MULT mod 2^64 and register it with key and payload.
  - S2 (T+2): bucket = prod[63:64-HASH_BITS]; register it.
  - addr = base + (bucket << ENTRY_SHIFT) mod 2^ADDR_W.
  - Output register (T+3): req_valid_out, addr, data, bucket.
  - Latency from fifo_read_en_out to req_valid_out is 3 cycles. Throughput is 1 tuple/clk.
- No internal backpressure; the pipeline always advances. The downstream prog_full threshold must leave at least 3 entries of slack, so at most 3 requests can land after req_afull_in rises.
- tuple_count_out increments with each req_valid_out.
- Upstream empty mid-run: no pop, pipeline bubbles, no spurious req_valid_out.
- Simultaneous afull and non-empty: afull wins, no pop.
- Reset mid-run: in-flight tuples are discarded, no requests emitted, FSM returns to IDLE.

Decomposition:
- Shared package holds:
  - HASH_MULT
  - default HASH_BITS, ENTRY_SHIFT and ADDR_W
  - FSM state encoding (IDLE=0, RUN=1, DRAIN=2, DONE=3)
  - the 128-bit request data layout: key at [63:0], payload at [127:64]
- One natural sub-module, mult_hash_stage: registered 64x64 truncated multiply plus bucket extraction (S1/S2), reusable by the probe engine.

Test Plan:
- base=0x1000, num=1, key=0x1, payload=0xAA -> one req 3 cycles after pop: bucket 0x9E37, addr 0x9F370, data {0xAA, 0x1}; done_out rises; tuple_count_out=1.
- num=3, keys 0, 1, 2 back-to-back, base=0 -> 3 reqs on consecutive cycles: buckets 0x0000, 0x9E37, 0x3C6E; addrs 0x0, 0x9E370, 0x3C6E0; done follows.
- num=0 start -> no fifo_read_en_out, no req, done_out within 2 cycles of start.
- req_afull_in held high with 10 tuples queued, num=10 -> no pops while high; on release, 10 reqs and done; fifo_read_en_out never asserted while afull=1.
- fifo_empty_in toggling every other cycle with num=4 -> exactly 4 pops, 4 reqs with bubbles, then done; extra queued tuples are not popped.
- rst_n pulled low 1 cycle after the 2nd pop of num=5 -> req_valid_out=0 immediately, FSM IDLE; a fresh start with num=2 produces exactly 2 reqs.
